// File: rtl/hazard_stall.sv
// Load-use / operand-timing stall unit with E/M producer tracking and mult/div busy counter.
// Latency: Stall, MD_Busy and Tnew_* are combinational from Instr_D and registered state (0 cycles).
// Backpressure: Stall holds PC and IF/ID and turns the ID/EX slot into a bubble; no upstream handshake.
module hazard_stall #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    output logic        Stall,
    output logic        MD_Busy,
    output logic [1:0]  Tnew_E,
    output logic [1:0]  Tnew_M
);

    localparam int MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    // One tracked in-flight write: destination register and cycles until its result exists.
    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tnew;
    } rec_t;

    rec_t             e_q, e_d;
    rec_t             m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       is_r, r_alu, i_alu, is_lui, is_lw, is_sw, is_br, is_jr, is_jal;
    logic       is_mult, is_div, is_mfhilo, is_mthilo;
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] dest_d;
    logic [1:0] tnew_d;
    logic       stall_rs, stall_rt, stall_md, md_start;
    logic       unused_shamt;

    assign opcode       = Instr_D[31:26];
    assign funct        = Instr_D[5:0];
    assign rs           = Instr_D[25:21];
    assign rt           = Instr_D[20:16];
    assign rd           = Instr_D[15:11];
    assign unused_shamt = ^Instr_D[10:6];

    // Instruction class decode.
    always_comb begin
        is_r      = (opcode == 6'h00);
        r_alu     = is_r && (funct == 6'h20 || funct == 6'h21 || funct == 6'h22 || funct == 6'h23 ||
                             funct == 6'h24 || funct == 6'h25 || funct == 6'h26 || funct == 6'h27 ||
                             funct == 6'h2a || funct == 6'h2b);
        is_jr     = is_r && (funct == 6'h08);
        is_mfhilo = is_r && (funct == 6'h10 || funct == 6'h12);
        is_mthilo = is_r && (funct == 6'h11 || funct == 6'h13);
        is_mult   = is_r && (funct == 6'h18 || funct == 6'h19);
        is_div    = is_r && (funct == 6'h1a || funct == 6'h1b);
        i_alu     = (opcode >= 6'h08) && (opcode <= 6'h0e);
        is_lui    = (opcode == 6'h0f);
        is_lw     = (opcode == 6'h23);
        is_sw     = (opcode == 6'h2b);
        is_br     = (opcode == 6'h04) || (opcode == 6'h05);
        is_jal    = (opcode == 6'h03);
    end

    // Operand use times (Tuse) and the producer record this instruction would carry into E.
    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
        dest_d  = 5'd0;
        tnew_d  = 2'd0;
        if (is_br) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end
        if (is_jr) begin
            use_rs = 1'b1;
        end
        if (r_alu || is_mult || is_div) begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
        end
        if (i_alu || is_lw || is_sw || is_mthilo) begin
            use_rs  = 1'b1;
            tuse_rs = 2'd1;
        end
        if (is_sw) begin
            use_rt  = 1'b1;
            tuse_rt = 2'd2;
        end
        if (r_alu || is_mfhilo) begin
            dest_d = rd;
            tnew_d = 2'd1;
        end else if (i_alu || is_lui) begin
            dest_d = rt;
            tnew_d = 2'd1;
        end else if (is_lw) begin
            dest_d = rt;
            tnew_d = 2'd2;
        end else if (is_jal) begin
            dest_d = 5'd31;
            tnew_d = 2'd0;
        end
    end

    // An operand is blocked if either tracked producer of it cannot deliver by its use time.
    function automatic logic blocked(input logic [4:0] src, input logic [1:0] tuse,
                                     input rec_t e, input rec_t m);
        return (src != 5'd0) &&
               (((src == e.addr) && (e.tnew > tuse)) || ((src == m.addr) && (m.tnew > tuse)));
    endfunction

    // Stall sources combine from decode and registered state only, so no loop through Stall.
    always_comb begin
        stall_rs = use_rs && blocked(rs, tuse_rs, e_q, m_q);
        stall_rt = use_rt && blocked(rt, tuse_rt, e_q, m_q);
        stall_md = (is_mult || is_div || is_mfhilo || is_mthilo) && (cnt_q != '0);
        Stall    = stall_rs || stall_rt || stall_md;
        MD_Busy  = (cnt_q != '0);
        Tnew_E   = e_q.tnew;
        Tnew_M   = m_q.tnew;
    end

    // Next state: advance E into M with saturating Tnew decrement, bubble E on stall, run MD counter.
    always_comb begin
        m_d.addr = e_q.addr;
        m_d.tnew = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
        e_d      = Stall ? '0 : '{addr: dest_d, tnew: tnew_d};
        md_start = (is_mult || is_div) && !Stall;
        cnt_d    = cnt_q;
        if (md_start) begin
            cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers; reset clears all tracking immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboard bench: an issue-timeline model predicts per-cycle outputs, a monitor compares them.
// Latency: one expectation per clock cycle, checked on the falling edge.
// Backpressure: stimulus holds an instruction in D for as long as the model says it stalls.
module tb_hazard_stall;

    logic        clk;
    logic        reset;
    logic [31:0] Instr_D;
    logic        Stall;
    logic        MD_Busy;
    logic [1:0]  Tnew_E;
    logic [1:0]  Tnew_M;

    hazard_stall #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Instr_D (Instr_D),
        .Stall   (Stall),
        .MD_Busy (MD_Busy),
        .Tnew_E  (Tnew_E),
        .Tnew_M  (Tnew_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_JR, K_JAL, K_J,
        K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO
    } kind_e;

    typedef struct {
        kind_e       k;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
    } ins_t;

    typedef struct {
        bit use_rs; int tuse_rs;
        bit use_rt; int tuse_rt;
        int dest;   int n;
        bit md_cls; int md_lat;
    } props_t;

    typedef struct { int t; int dest; int n; } issued_t;

    typedef struct packed {
        logic       stall;
        logic       busy;
        logic [1:0] te;
        logic [1:0] tm;
    } exp_t;

    exp_t    exp_q[$];
    issued_t hist[$];
    int      cyc;
    int      md_end;
    int      vectors;
    int      miscompares;

    function automatic logic [31:0] enc(input ins_t i);
        logic [31:0] w;
        case (i.k)
            K_ADDU:  w = {6'h00, i.rs, i.rt, i.rd, 5'h00, 6'h21};
            K_SUBU:  w = {6'h00, i.rs, i.rt, i.rd, 5'h00, 6'h23};
            K_ORI:   w = {6'h0d, i.rs, i.rt, i.imm};
            K_LUI:   w = {6'h0f, 5'h00, i.rt, i.imm};
            K_LW:    w = {6'h23, i.rs, i.rt, i.imm};
            K_SW:    w = {6'h2b, i.rs, i.rt, i.imm};
            K_BEQ:   w = {6'h04, i.rs, i.rt, i.imm};
            K_BNE:   w = {6'h05, i.rs, i.rt, i.imm};
            K_JR:    w = {6'h00, i.rs, 15'h0000, 6'h08};
            K_JAL:   w = {6'h03, i.tgt};
            K_J:     w = {6'h02, i.tgt};
            K_MULT:  w = {6'h00, i.rs, i.rt, 10'h000, 6'h18};
            K_MULTU: w = {6'h00, i.rs, i.rt, 10'h000, 6'h19};
            K_DIV:   w = {6'h00, i.rs, i.rt, 10'h000, 6'h1a};
            K_DIVU:  w = {6'h00, i.rs, i.rt, 10'h000, 6'h1b};
            K_MFHI:  w = {16'h0000, i.rd, 5'h00, 6'h10};
            K_MFLO:  w = {16'h0000, i.rd, 5'h00, 6'h12};
            K_MTHI:  w = {6'h00, i.rs, 15'h0000, 6'h11};
            K_MTLO:  w = {6'h00, i.rs, 15'h0000, 6'h13};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // What each instruction reads, when it needs it, and what it will write when.
    function automatic props_t props(input ins_t i);
        props_t p;
        p = '{use_rs: 0, tuse_rs: 0, use_rt: 0, tuse_rt: 0, dest: 0, n: 0, md_cls: 0, md_lat: 0};
        case (i.k)
            K_ADDU, K_SUBU: begin p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1;
                                  p.dest = int'(i.rd); p.n = 1; end
            K_ORI:          begin p.use_rs = 1; p.tuse_rs = 1; p.dest = int'(i.rt); p.n = 1; end
            K_LUI:          begin p.dest = int'(i.rt); p.n = 1; end
            K_LW:           begin p.use_rs = 1; p.tuse_rs = 1; p.dest = int'(i.rt); p.n = 2; end
            K_SW:           begin p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 2; end
            K_BEQ, K_BNE:   begin p.use_rs = 1; p.use_rt = 1; end
            K_JR:           begin p.use_rs = 1; end
            K_JAL:          begin p.dest = 31; p.n = 0; end
            K_MULT, K_MULTU: begin p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1;
                                   p.md_cls = 1; p.md_lat = 5; end
            K_DIV, K_DIVU:  begin p.use_rs = 1; p.tuse_rs = 1; p.use_rt = 1; p.tuse_rt = 1;
                                  p.md_cls = 1; p.md_lat = 10; end
            K_MFHI, K_MFLO: begin p.md_cls = 1; p.dest = int'(i.rd); p.n = 1; end
            K_MTHI, K_MTLO: begin p.use_rs = 1; p.tuse_rs = 1; p.md_cls = 1; end
            default: ;
        endcase
        return p;
    endfunction

    // A value written by an instruction issued at cycle t with Tnew n is usable by a
    // reader in D at cycle c with use time u once c + u >= t + n + 1.
    function automatic bit src_blocked(input logic [4:0] src, input int u);
        bit b;
        b = 0;
        if (src != 5'd0)
            foreach (hist[j])
                if (hist[j].dest == int'(src) && (cyc + u) < (hist[j].t + hist[j].n + 1)) b = 1;
        return b;
    endfunction

    // Tnew seen in a stage: the instruction issued 'age' cycles ago, decremented while in M.
    function automatic logic [1:0] tnew_of(input int age);
        int v;
        v = 0;
        foreach (hist[j])
            if (hist[j].t == cyc - age) v = hist[j].n - (age - 1);
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    function automatic logic [4:0] rr();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    function automatic ins_t mk(input kind_e k, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
        ins_t i;
        i.k = k; i.rs = rs; i.rt = rt; i.rd = rd;
        i.imm = 16'($urandom);
        i.tgt = 26'($urandom);
        return i;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock of stimulus: predict, push expectation, update the model, advance.
    task automatic step(input ins_t ins, output bit st, output bit dut_st);
        props_t p;
        exp_t   e;
        bit     busy;
        p    = props(ins);
        busy = (cyc <= md_end);
        st   = (p.use_rs && src_blocked(ins.rs, p.tuse_rs)) ||
               (p.use_rt && src_blocked(ins.rt, p.tuse_rt)) ||
               (p.md_cls && busy);
        e.stall = st;
        e.busy  = busy;
        e.te    = tnew_of(1);
        e.tm    = tnew_of(2);
        Instr_D = enc(ins);
        exp_q.push_back(e);
        if (!st) begin
            hist.push_back('{t: cyc, dest: p.dest, n: p.n});
            if (p.md_lat > 0) md_end = cyc + p.md_lat;
        end
        while (hist.size() > 0 && hist[0].t < cyc - 3) void'(hist.pop_front());
        #2 dut_st = Stall;
        @(posedge clk);
        #1 cyc++;
    endtask

    // Present an instruction in D until it issues; report how many cycles the DUT stalled it.
    task automatic issue(input ins_t ins, output int n_dut);
        bit st, ds;
        bit done;
        n_dut = 0;
        done  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(ins, st, ds);
            if (ds) n_dut++;
            if (!st) done = 1;
        end
    endtask

    task automatic flush();
        int d;
        for (int k = 0; k < 3; k++) issue(mk(K_NOP, 5'd0, 5'd0, 5'd0), d);
    endtask

    // Compare every cycle's observed outputs with the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if ({Stall, MD_Busy, Tnew_E, Tnew_M} !== e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs: got stall=%b busy=%b te=%0d tm=%0d expected stall=%b busy=%b te=%0d tm=%0d (t=%0t)",
                             Stall, MD_Busy, Tnew_E, Tnew_M, e.stall, e.busy, e.te, e.tm, $time);
                end
            end
        end
    end

    initial begin
        int   n;
        bit   st, ds;
        ins_t mflo;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        md_end      = -1;
        reset       = 1'b1;
        Instr_D     = 32'h0;
        #1;
        chk("reset_stall", int'(Stall), 0);
        chk("reset_busy", int'(MD_Busy), 0);
        chk("reset_tnew_e", int'(Tnew_E), 0);
        chk("reset_tnew_m", int'(Tnew_M), 0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        flush();

        issue(mk(K_LW, 5'd2, 5'd1, 5'd0), n);
        issue(mk(K_ADDU, 5'd1, 5'd3, 5'd2), n);
        chk("lw_addu_stalls", n, 1);
        flush();
        issue(mk(K_LW, 5'd2, 5'd1, 5'd0), n);
        issue(mk(K_BEQ, 5'd1, 5'd0, 5'd0), n);
        chk("lw_beq_stalls", n, 2);
        flush();
        issue(mk(K_ORI, 5'd0, 5'd1, 5'd0), n);
        issue(mk(K_BEQ, 5'd1, 5'd0, 5'd0), n);
        chk("ori_beq_stalls", n, 1);
        flush();
        issue(mk(K_ORI, 5'd0, 5'd1, 5'd0), n);
        issue(mk(K_SW, 5'd2, 5'd1, 5'd0), n);
        chk("ori_sw_stalls", n, 0);
        flush();
        issue(mk(K_JAL, 5'd0, 5'd0, 5'd0), n);
        issue(mk(K_JR, 5'd31, 5'd0, 5'd0), n);
        chk("jal_jr_stalls", n, 0);
        flush();
        issue(mk(K_ADDU, 5'd1, 5'd2, 5'd0), n);
        issue(mk(K_BEQ, 5'd0, 5'd0, 5'd0), n);
        chk("zero_dest_stalls", n, 0);
        flush();
        issue(mk(K_ORI, 5'd0, 5'd5, 5'd0), n);
        issue(mk(K_LW, 5'd0, 5'd5, 5'd0), n);
        issue(mk(K_ADDU, 5'd5, 5'd0, 5'd7), n);
        chk("lw_e_ori_m_stalls", n, 1);
        flush();
        issue(mk(K_DIV, 5'd4, 5'd5, 5'd0), n);
        issue(mk(K_MFLO, 5'd0, 5'd0, 5'd6), n);
        chk("div_mflo_stalls", n, 10);
        flush();

        // Reset in the middle of a divide, with mflo waiting in D.
        issue(mk(K_DIV, 5'd4, 5'd5, 5'd0), n);
        mflo = mk(K_MFLO, 5'd0, 5'd0, 5'd6);
        for (int k = 0; k < 3; k++) step(mflo, st, ds);
        Instr_D = enc(mflo);
        #1;
        chk("pre_reset_busy", int'(MD_Busy), (cyc <= md_end) ? 1 : 0);
        chk("pre_reset_stall", int'(Stall), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_stall", int'(Stall), 0);
        chk("async_reset_busy", int'(MD_Busy), 0);
        chk("async_reset_tnew_e", int'(Tnew_E), 0);
        chk("async_reset_tnew_m", int'(Tnew_M), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hist.delete();
        md_end = -1;
        cyc++;
        issue(mflo, n);
        chk("post_reset_mflo_stalls", n, 0);
        flush();

        for (int k = 0; k < 400; k++) begin
            kind_e k_sel;
            k_sel = kind_e'($urandom_range(0, 19));
            if ((k_sel == K_DIV || k_sel == K_DIVU) && $urandom_range(0, 3) != 0) k_sel = K_ADDU;
            issue(mk(k_sel, rr(), rr(), rr()), n);
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
